// File: rtl/trace_filter_multi_if.sv
// Trace tap bundle: retired-instruction stream in, filtered verdict out.
// The tap (master) drives pc_valid/instr; the filter (slave) returns the registered verdict.
interface trace_filter_multi_if #(
   parameter int INSTR_W = 32
);
   logic               pc_valid;
   logic [INSTR_W-1:0] instr;
   logic               out_valid;
   logic               out_keep;
   logic [4:0]         out_reason;

   modport master (
      output pc_valid, instr,
      input  out_valid, out_keep, out_reason
   );

   modport slave (
      input  pc_valid, instr,
      output out_valid, out_keep, out_reason
   );
endinterface

// File: rtl/trace_filter_multi.sv
// Classifies retired instructions (branch/jump/WFI/matchers) plus trailing runs; keeps or drops each.
// Latency: verdict registered exactly one cycle after pc_valid. Optional stats under TRACE_FILTER_STATS_EN.
// Backpressure: none; every input cycle produces an output cycle.
module trace_filter_multi #(
   parameter int INSTR_W      = 32,
   parameter int NUM_MATCHERS = 2,
   parameter int AFTER_CNT_W  = 4,
   parameter int STAT_W       = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   trace_filter_multi_if.slave               trc,
   input  logic [2:0]                        cfg_class_en,
   input  logic [2:0]                        cfg_after_en,
   input  logic [AFTER_CNT_W-1:0]            cfg_after_count,
   input  logic [NUM_MATCHERS-1:0]           cfg_match_en,
   input  logic [NUM_MATCHERS*INSTR_W-1:0]   cfg_match_value,
   input  logic [NUM_MATCHERS*INSTR_W-1:0]   cfg_match_mask,
   input  logic                              cfg_match_after,
   input  logic                              clr_stats,
   output logic [STAT_W-1:0]                 keep_count,
   output logic [STAT_W-1:0]                 drop_count
);

   logic                    is_branch;
   logic                    is_jump;
   logic                    is_wfi;
   logic                    is_rvc;
   logic [2:0]              cls;
   logic [2:0]              hit_class;
   logic [NUM_MATCHERS-1:0] match;
   logic                    hit_match;
   logic                    trail;
   logic                    keep;
   logic                    trig;
   logic [AFTER_CNT_W-1:0]  rem;
   logic [AFTER_CNT_W-1:0]  rem_nxt;

   always_comb begin
      is_rvc    = (trc.instr[1:0] != 2'b11);
      is_branch = (trc.instr[6:0] == 7'b1100011)
               || (is_rvc && trc.instr[1:0] == 2'b01 && trc.instr[15:14] == 2'b11);
      is_jump   = (trc.instr[6:0] == 7'b1101111) || (trc.instr[6:0] == 7'b1100111)
               || (is_rvc && trc.instr[1:0] == 2'b01 && trc.instr[14:13] == 2'b01)
               || (is_rvc && trc.instr[1:0] == 2'b10 && trc.instr[15:13] == 3'b100
                   && trc.instr[6:2] == 5'd0 && trc.instr[11:7] != 5'd0);
      is_wfi    = (trc.instr == INSTR_W'(32'h10500073));
      cls       = {is_wfi, is_jump, is_branch};
   end

   // A zero mask compares no bits, so an enabled matcher with mask 0 hits everything.
   always_comb begin
      match = '0;
      for (int i = 0; i < NUM_MATCHERS; i++) begin
         match[i] = cfg_match_en[i]
                 && (((trc.instr ^ cfg_match_value[i*INSTR_W +: INSTR_W])
                      & cfg_match_mask[i*INSTR_W +: INSTR_W]) == '0);
      end
   end

   always_comb begin
      hit_class = cls & cfg_class_en;
      hit_match = |match;
      trail     = (rem != '0);
      keep      = (|hit_class) || hit_match || trail;
      trig      = (|(cls & cfg_after_en)) || (hit_match && cfg_match_after);
      rem_nxt   = rem;
      if (trc.pc_valid) begin
         if (trig)
            rem_nxt = cfg_after_count;
         else if (trail)
            rem_nxt = rem - AFTER_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem            <= '0;
         trc.out_valid  <= 1'b0;
         trc.out_keep   <= 1'b0;
         trc.out_reason <= 5'd0;
      end else begin
         rem            <= rem_nxt;
         trc.out_valid  <= trc.pc_valid;
         trc.out_keep   <= trc.pc_valid && keep;
         trc.out_reason <= trc.pc_valid ? {trail, hit_match, hit_class} : 5'd0;
      end
   end

`ifdef TRACE_FILTER_STATS_EN
   // Clear wins over a same-cycle increment; counters stick at all-ones.
   always_ff @(posedge clk) begin
      if (rst || clr_stats) begin
         keep_count <= '0;
         drop_count <= '0;
      end else if (trc.pc_valid) begin
         if (keep) begin
            if (keep_count != '1)
               keep_count <= keep_count + STAT_W'(1);
         end else begin
            if (drop_count != '1)
               drop_count <= drop_count + STAT_W'(1);
         end
      end
   end
`else
   logic unused_clr_stats;
   assign unused_clr_stats = clr_stats;
   assign keep_count       = '0;
   assign drop_count       = '0;
`endif

endmodule

// File: tb/tb_trace_filter_multi.sv
// Directed bench for trace_filter_multi: expected verdicts queued at drive time, popped one cycle later.
module tb_trace_filter_multi;
   localparam int NM = 2;
   localparam int SW = 4;

   localparam logic [31:0] BEQ  = 32'h00000463;
   localparam logic [31:0] NOP  = 32'h00000013;
   localparam logic [31:0] JAL  = 32'h0000006F;
   localparam logic [31:0] JALR = 32'h00008067;
   localparam logic [31:0] WFI  = 32'h10500073;

   // Expected output encoding: {out_valid, out_keep, out_reason[4:0]}
   localparam logic [6:0] DROP = 7'b1_0_00000;
   localparam logic [6:0] IDLE = 7'b0_0_00000;
   localparam logic [6:0] K_BR = 7'b1_1_00001;
   localparam logic [6:0] K_JP = 7'b1_1_00010;
   localparam logic [6:0] K_WF = 7'b1_1_00100;
   localparam logic [6:0] K_MT = 7'b1_1_01000;
   localparam logic [6:0] K_TR = 7'b1_1_10000;
   localparam logic [6:0] K_TB = 7'b1_1_10001;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [2:0]           cfg_class_en;
   logic [2:0]           cfg_after_en;
   logic [3:0]           cfg_after_count;
   logic [NM-1:0]        cfg_match_en;
   logic [NM*32-1:0]     cfg_match_value;
   logic [NM*32-1:0]     cfg_match_mask;
   logic                 cfg_match_after;
   logic                 clr_stats;
   logic [SW-1:0]        keep_count;
   logic [SW-1:0]        drop_count;

   int total = 0;
   int bad   = 0;
   logic [6:0] exp_q[$];

   trace_filter_multi_if #(.INSTR_W(32)) trc ();

   trace_filter_multi #(
      .INSTR_W(32), .NUM_MATCHERS(NM), .AFTER_CNT_W(4), .STAT_W(SW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .trc             (trc.slave),
      .cfg_class_en    (cfg_class_en),
      .cfg_after_en    (cfg_after_en),
      .cfg_after_count (cfg_after_count),
      .cfg_match_en    (cfg_match_en),
      .cfg_match_value (cfg_match_value),
      .cfg_match_mask  (cfg_match_mask),
      .cfg_match_after (cfg_match_after),
      .clr_stats       (clr_stats),
      .keep_count      (keep_count),
      .drop_count      (drop_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [31:0] ins, input logic [6:0] exp, input string tag);
      logic [6:0] e;
      trc.pc_valid = v;
      trc.instr    = ins;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check(tag, {25'd0, trc.out_valid, trc.out_keep, trc.out_reason}, {25'd0, e});
      trc.pc_valid = 1'b0;
   endtask

   task automatic chk_stats(input string tag, input logic [SW-1:0] k, input logic [SW-1:0] d);
`ifdef TRACE_FILTER_STATS_EN
      check({tag, "_keep"}, 32'(keep_count), 32'(k));
      check({tag, "_drop"}, 32'(drop_count), 32'(d));
`else
      check({tag, "_keep"}, 32'(keep_count), 32'(k & 4'h0));
      check({tag, "_drop"}, 32'(drop_count), 32'(d & 4'h0));
`endif
   endtask

   initial begin
      rst             = 1'b1;
      trc.pc_valid    = 1'b0;
      trc.instr       = '0;
      cfg_class_en    = 3'b111;
      cfg_after_en    = 3'b000;
      cfg_after_count = 4'd0;
      cfg_match_en    = '0;
      cfg_match_value = '0;
      cfg_match_mask  = '0;
      cfg_match_after = 1'b0;
      clr_stats       = 1'b0;
      step(1'b0, NOP, IDLE, "reset0");
      step(1'b1, BEQ, IDLE, "reset1");
      chk_stats("reset", 4'd0, 4'd0);
      rst = 1'b0;

      // Class keep without trailing
      step(1'b1, BEQ, K_BR, "beq");
      step(1'b1, NOP, DROP, "nop");
      chk_stats("t1", 4'd1, 4'd1);

      // Jump triggers 3 trailing; bubble holds the count
      cfg_after_en = 3'b010; cfg_after_count = 4'd3;
      step(1'b1, JAL, K_JP, "jal");
      step(1'b1, NOP, K_TR, "trail1");
      step(1'b1, NOP, K_TR, "trail2");
      step(1'b0, NOP, IDLE, "bubble");
      step(1'b1, NOP, K_TR, "trail3");
      step(1'b1, NOP, DROP, "after4");
      step(1'b1, NOP, DROP, "after5");

      // Reload replaces residual count
      cfg_after_en = 3'b001; cfg_after_count = 4'd2;
      step(1'b1, BEQ, K_BR, "rl_beq1");
      step(1'b1, NOP, K_TR, "rl_nop1");
      step(1'b1, BEQ, K_TB, "rl_beq2");
      step(1'b1, NOP, K_TR, "rl_nop2");
      step(1'b1, NOP, K_TR, "rl_nop3");
      step(1'b1, NOP, DROP, "rl_nop4");

      // Matcher on opcode field only
      cfg_class_en = 3'b000; cfg_after_en = 3'b000;
      cfg_match_value[31:0] = 32'h00000073;
      cfg_match_mask[31:0]  = 32'h0000007F;
      cfg_match_en = 2'b01;
      step(1'b1, WFI, K_MT, "m_wfi");
      step(1'b1, NOP, DROP, "m_nop");
      cfg_match_after = 1'b1; cfg_after_count = 4'd1;
      step(1'b1, WFI, K_MT, "ma_wfi");
      step(1'b1, NOP, K_TR, "ma_trail");
      step(1'b1, NOP, DROP, "ma_end");
      cfg_match_after = 1'b0;
      cfg_match_en = 2'b10;
      step(1'b1, NOP, K_MT, "m_zero_mask");
      cfg_match_en = 2'b00;
      step(1'b1, NOP, DROP, "m_off");

      // Compressed and other decodes
      cfg_class_en = 3'b111;
      step(1'b1, 32'h0000C001, K_BR, "c_beqz");
      step(1'b1, 32'h00008082, K_JP, "c_jr");
      step(1'b1, 32'h00008002, DROP, "c_rs1_0");
      step(1'b1, JALR, K_JP, "jalr");
      step(1'b1, WFI, K_WF, "wfi");

      // Dropped-class branch still starts a trailing run
      cfg_class_en = 3'b110; cfg_after_en = 3'b001; cfg_after_count = 4'd1;
      step(1'b1, BEQ, DROP, "br_drop_trig");
      step(1'b1, NOP, K_TR, "br_trail");
      step(1'b1, NOP, DROP, "br_end");

      // Mid-run reset clears the trailing count
      cfg_class_en = 3'b111; cfg_after_en = 3'b010; cfg_after_count = 4'd5;
      step(1'b1, JAL, K_JP, "rr_jal");
      step(1'b1, NOP, K_TR, "rr_trail");
      rst = 1'b1;
      step(1'b1, NOP, IDLE, "rr_rst");
      rst = 1'b0;
      step(1'b1, NOP, DROP, "rr_fresh");

      // Statistics: clear priority and saturation
      cfg_after_en = 3'b000;
      clr_stats = 1'b1;
      step(1'b1, NOP, DROP, "s_clr");
      clr_stats = 1'b0;
      chk_stats("s_clr", 4'd0, 4'd0);
      for (int i = 0; i < 15; i++) step(1'b1, BEQ, K_BR, "s_fill");
      chk_stats("s_full", 4'hF, 4'd0);
      step(1'b1, BEQ, K_BR, "s_sat");
      chk_stats("s_sat", 4'hF, 4'd0);
      step(1'b1, NOP, DROP, "s_drop");
      chk_stats("s_drop", 4'hF, 4'd1);
      clr_stats = 1'b1;
      step(1'b1, BEQ, K_BR, "s_clr2");
      clr_stats = 1'b0;
      chk_stats("s_clr2", 4'd0, 4'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
